// File: rtl/data_mem_ctrl.sv
// Data-memory access controller between the MEM stage and the data bus.
// Turns a load/store into a word-aligned bus request with byte strobes,
// waits for mem_ready (bounded by a timeout), and returns extended load data.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] alu_result_in,
  input  logic [31:0]           mux2_result_in,
  output logic                  stall_out,
  output logic [31:0]           read_data_out,
  output logic                  load_valid_out,
  output logic                  misaligned_out,
  output logic                  bus_error_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         off_q;
  logic [2:0]         funct3_q;
  logic               we_q;

  logic               access_c;
  logic               aligned_c;
  logic               start_c;
  logic               finish_ok_c;
  logic               timeout_c;
  logic               misalign_c;
  logic [3:0]         wstrb_c;
  logic [31:0]        wdata_c;
  logic [31:0]        lane_c;
  logic [31:0]        load_ext_c;

  assign access_c = mem_read_in | mem_write_in;

  // Alignment check; a simultaneous read+write is treated as a store
  always_comb begin
    aligned_c = 1'b1;
    case (funct3_in[1:0])
      2'b01:   aligned_c = ~alu_result_in[0];
      2'b10:   aligned_c = (alu_result_in[1:0] == 2'b00);
      2'b11:   aligned_c = 1'b0;
      default: aligned_c = 1'b1;
    endcase
    if (!mem_write_in && (funct3_in[2:1] == 2'b11)) aligned_c = 1'b0;
  end

  // Store strobes and lane-replicated store data
  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = mux2_result_in;
    case (funct3_in[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << alu_result_in[1:0];
        wdata_c = {4{mux2_result_in[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << alu_result_in[1:0];
        wdata_c = {2{mux2_result_in[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = mux2_result_in;
      end
    endcase
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    lane_c     = mem_rdata >> {off_q, 3'b000};
    load_ext_c = lane_c;
    case (funct3_q)
      3'b000:  load_ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  load_ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b100:  load_ext_c = {24'd0, lane_c[7:0]};
      3'b101:  load_ext_c = {16'd0, lane_c[15:0]};
      default: load_ext_c = lane_c;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait counter and combinational stall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_c     = 1'b0;
    finish_ok_c = 1'b0;
    timeout_c   = 1'b0;
    misalign_c  = 1'b0;
    stall_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          if (aligned_c) begin
            start_c   = 1'b1;
            stall_out = 1'b1;
            cnt_d     = '0;
            state_d   = S_BUSY;
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      S_BUSY: begin
        stall_out = 1'b1;
        if (mem_ready) begin
          finish_ok_c = 1'b1;
          state_d     = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latched request, bus outputs and completion pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      off_q          <= '0;
      funct3_q       <= '0;
      we_q           <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      read_data_out  <= '0;
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_error_out  <= 1'b0;
    end else begin
      misaligned_out <= misalign_c;
      bus_error_out  <= timeout_c;
      load_valid_out <= (finish_ok_c | timeout_c) & ~we_q;
      if (finish_ok_c && !we_q) begin
        read_data_out <= load_ext_c;
      end else if (timeout_c && !we_q) begin
        read_data_out <= '0;
      end
      if (start_c) begin
        off_q     <= alu_result_in[1:0];
        funct3_q  <= funct3_in;
        we_q      <= mem_write_in;
        mem_req   <= 1'b1;
        mem_we    <= mem_write_in;
        mem_addr  <= {alu_result_in[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata <= wdata_c;
        mem_wstrb <= mem_write_in ? wstrb_c : 4'b0000;
      end else if (finish_ok_c || timeout_c) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory access controller that sits directly downstream of the MEM pipeline stage and sits between it and the external data-memory bus. It takes the load/store request from MEM and does the following:
- converts it into a word-aligned bus transaction with byte strobes;
- waits on a ready handshake, with a timeout;
- returns sign- or zero-extended load data;
- holds the pipeline via stall_out until the access completes.

Parameters:
ADDR_WIDTH, 32, width of byte address from ALU and of mem_addr.
TIMEOUT_CYCLES, 16, maximum BUSY cycles waiting for mem_ready before a bus error is declared (>=1).

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
mem_read_in  input  1  load request from MEM stage.
mem_write_in  input  1  store request from MEM stage.
funct3_in  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
alu_result_in  input  ADDR_WIDTH  byte address.
mux2_result_in  input  32  store data (rs2 value).
stall_out  output  1  holds PC, IF/ID, ID/EX, EX/MEM while high.
read_data_out  output  32  extended load result.
load_valid_out  output  1  one-cycle pulse; read_data_out updated this cycle.
misaligned_out  output  1  one-cycle pulse; access rejected.
bus_error_out  output  1  one-cycle pulse; timeout occurred.
mem_req  output  1  bus request, held until mem_ready.
mem_we  output  1  1 = write.
mem_addr  output  ADDR_WIDTH  word address, low two bits forced to 0.
mem_wdata  output  32  lane-replicated store data.
mem_wstrb  output  4  byte enables; 0000 on reads.
mem_ready  input  1  bus completes transaction in the cycle it is sampled high with mem_req.
mem_rdata  input  32  read word, valid with mem_ready.

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0, including read_data_out and the timeout counter. Reset mid-BUSY drops mem_req at that edge; the transaction is abandoned with no pulses.
- States are IDLE, BUSY and DONE.
- access = mem_read_in | mem_write_in.
- If both request inputs are high, the access is a store and the read is ignored.
- Alignment rules:
  - funct3[1:0]=01 requires addr[0]=0.
  - funct3[1:0]=10 requires addr[1:0]=00.
  - funct3[1:0]=11, or funct3=110/111 on a load, is treated as misaligned.
- IDLE with a misaligned access: misaligned_out=1 next cycle for one cycle; no bus request; stall_out=0; stay IDLE.
- IDLE with an aligned access:
  - stall_out=1 combinationally in that cycle.
  - Latch addr, data, funct3 and we.
  - Go to BUSY with mem_req=1 from the next cycle.
- stall_out = (IDLE & access & aligned) | BUSY. It is low in DONE.
- Store strobes and data:
  - sb: wstrb = 0001<<addr[1:0]; wdata = {4{data[7:0]}}.
  - sh: wstrb = 0011<<addr[1:0]; wdata = {2{data[15:0]}}.
  - sw: wstrb = 1111; wdata = data.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are stable every cycle.
  - The counter increments each BUSY cycle without ready.
- mem_ready=1 in BUSY: capture mem_rdata and go to DONE. Minimum latency, access seen to DONE, is 2 cycles.
- Counter reaches TIMEOUT_CYCLES without ready:
  - drop mem_req;
  - bus_error_out=1 in DONE;
  - for a load, read_data_out=0 and load_valid_out=1;
  - go to DONE.
- DONE: one cycle.
  - For a load, load_valid_out=1 and read_data_out is updated.
  - Inputs are ignored, because the same instruction is still presented in this cycle.
  - Next state is IDLE.
- Load extraction: lane = rdata >> (8*addr[1:0]).
  - b: sign-extend lane[7:0].
  - bu: zero-extend lane[7:0].
  - h: sign-extend lane[15:0].
  - hu: zero-extend lane[15:0].
  - w: rdata.
- read_data_out holds its value until the next completed load. Stores never change it.
- mem_ready while not in BUSY is ignored.

Test Plan:
- Reset, then lw at 0x100 with mem_ready on the 1st BUSY cycle and rdata=0xDEADBEEF:
  - mem_addr=0x100, wstrb=0000;
  - stall high for 2 cycles;
  - DONE gives read_data_out=0xDEADBEEF, load_valid_out=1.
- lb at 0x103 with rdata=0x80FF_0000 -> read_data_out=0xFFFFFF80. lbu at 0x103 with the same rdata -> 0x00000080. lhu at 0x102 with the same rdata -> 0x000080FF.
- sb at 0x0A1 with data 0x123456AB -> mem_addr=0x0A0, wstrb=0010, wdata=0xABABABAB, mem_we=1. sh at 0x0A2 -> wstrb=1100.
- lw at 0x102 -> misaligned_out pulse, mem_req never rises, stall_out=0. sh at 0x001 gives the same response.
- lw with mem_ready held low, TIMEOUT_CYCLES=16 -> mem_req high for exactly 16 cycles, then bus_error_out=1, read_data_out=0, stall released.
- Reset asserted on the 3rd BUSY cycle -> next cycle mem_req=0, stall_out=0, no pulses. A following lw completes normally.
